// File: rtl/mux_scan_reg.sv
// mux_scan_reg: registered N_CH-channel, DW-bit multiplexer with manual select
// and round-robin auto-scan. Every output is taken straight from a flop, so
// no input reaches an output combinationally.
// Optional build macro MUX_SCAN_MASK_EN adds the ch_mask input.
// With ch_mask, SCAN skips masked channels and MANUAL treats them as illegal.
// Without the macro, every channel is treated as enabled.
module mux_scan_reg #(
    parameter int N_CH  = 4,
    parameter int DW    = 1,
    parameter int DWELL = 4,
    localparam int SELW = $clog2(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
`ifdef MUX_SCAN_MASK_EN
    input  logic [N_CH-1:0]      ch_mask,
`endif
    input  logic [N_CH*DW-1:0]   din,
    output logic [DW-1:0]        dout,
    output logic [SELW-1:0]      cur_ch,
    output logic                 valid,
    output logic                 wrap
);

    localparam int              CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
    localparam logic [SELW:0]   NCH_W    = (SELW + 1)'(N_CH);

    typedef enum logic {
        MANUAL,
        SCAN
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    logic [N_CH-1:0] ch_en;

`ifdef MUX_SCAN_MASK_EN
    assign ch_en = ch_mask;
`else
    assign ch_en = '1;
`endif

    // Indices beyond N_CH-1 (non power-of-2 N_CH) match no loop entry, so they
    // come out as not ok with zero data.
    logic            man_ok;
    logic [DW-1:0]   man_data;
    logic            cur_legal;
    logic            cur_ok;
    logic [DW-1:0]   cur_data;

    // Decode the manual select and the current channel into data plus an enabled flag.
    always_comb begin
        man_ok    = 1'b0;
        man_data  = '0;
        cur_ok    = 1'b0;
        cur_data  = '0;
        cur_legal = ({1'b0, cur_ch} < NCH_W);
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (SELW'(k) == sel) begin
                man_ok   = ch_en[k];
                man_data = din[k*DW +: DW];
            end
            if (SELW'(k) == cur_ch) begin
                cur_ok   = ch_en[k];
                cur_data = din[k*DW +: DW];
            end
        end
    end

    // The next scan channel is the lowest enabled index above cur_ch. If there
    // is none, the scan wraps to the lowest enabled index, which may be cur_ch
    // itself when only one channel is enabled. Every such wrap passes N_CH-1.
    logic            hi_found;
    logic [SELW-1:0] hi_ch;
    logic [DW-1:0]   hi_data;
    logic            lo_found;
    logic [SELW-1:0] lo_ch;
    logic [DW-1:0]   lo_data;
    logic            nxt_found;
    logic [SELW-1:0] nxt_ch;
    logic [DW-1:0]   nxt_data;
    logic            nxt_wrap;

    // Search for the next enabled channel in round-robin order.
    always_comb begin
        hi_found = 1'b0;
        hi_ch    = '0;
        hi_data  = '0;
        lo_found = 1'b0;
        lo_ch    = '0;
        lo_data  = '0;
        for (int unsigned j = 0; j < N_CH; j++) begin
            if (!hi_found && ch_en[j] && (SELW'(j) > cur_ch)) begin
                hi_found = 1'b1;
                hi_ch    = SELW'(j);
                hi_data  = din[j*DW +: DW];
            end
            if (!lo_found && ch_en[j]) begin
                lo_found = 1'b1;
                lo_ch    = SELW'(j);
                lo_data  = din[j*DW +: DW];
            end
        end
        nxt_found = hi_found | lo_found;
        nxt_ch    = hi_found ? hi_ch   : lo_ch;
        nxt_data  = hi_found ? hi_data : lo_data;
        nxt_wrap  = !hi_found && lo_found;
    end

    // Mode FSM with dwell counter and registered outputs.
    // rst overrides en. en=0 holds all state and only clears the wrap pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= MANUAL;
            cnt    <= '0;
            cur_ch <= '0;
            dout   <= '0;
            valid  <= 1'b0;
            wrap   <= 1'b0;
        end else if (!en) begin
            wrap <= 1'b0;
        end else if (!mode) begin
            // Manual mode, including the edge that leaves SCAN.
            state  <= MANUAL;
            cnt    <= '0;
            wrap   <= 1'b0;
            cur_ch <= sel;
            dout   <= man_ok ? man_data : '0;
            valid  <= man_ok;
        end else if (state == MANUAL) begin
            // Entering SCAN: the dwell restarts on the current channel. An
            // illegal manual index is replaced by channel 0.
            state <= SCAN;
            cnt   <= '0;
            wrap  <= 1'b0;
            if (cur_legal) begin
                dout  <= cur_ok ? cur_data : '0;
                valid <= cur_ok;
            end else begin
                cur_ch <= '0;
                dout   <= ch_en[0] ? din[DW-1:0] : '0;
                valid  <= ch_en[0];
            end
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (nxt_found) begin
                cur_ch <= nxt_ch;
                dout   <= nxt_data;
                valid  <= 1'b1;
                wrap   <= nxt_wrap;
            end else begin
                dout  <= '0;
                valid <= 1'b0;
                wrap  <= 1'b0;
            end
        end else begin
            cnt   <= cnt + 1'b1;
            dout  <= cur_ok ? cur_data : '0;
            valid <= cur_ok;
            wrap  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_scan_reg.sv
// tb_mux_scan_reg: randomized and directed self-checking bench for mux_scan_reg.
// It drives two instances at once:
//   A: N_CH=4, DW=1, DWELL=4.
//   B: N_CH=3, DW=8, DWELL=1.
// Define MUX_SCAN_MASK_EN to connect ch_mask and run the mask scenario.
module tb_mux_scan_reg;

    logic        clk;
    logic        rst;
    logic        en;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  a_din;
    logic [23:0] b_din;
    logic [3:0]  a_mask;
    logic [2:0]  b_mask;

    logic        a_dout;
    logic [1:0]  a_cur;
    logic        a_valid;
    logic        a_wrap;
    logic [7:0]  b_dout;
    logic [1:0]  b_cur;
    logic        b_valid;
    logic        b_wrap;

    int checks = 0;
    int errors = 0;

    mux_scan_reg #(.N_CH(4), .DW(1), .DWELL(4)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
`ifdef MUX_SCAN_MASK_EN
        .ch_mask(a_mask),
`endif
        .din(a_din), .dout(a_dout), .cur_ch(a_cur), .valid(a_valid), .wrap(a_wrap)
    );

    mux_scan_reg #(.N_CH(3), .DW(8), .DWELL(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
`ifdef MUX_SCAN_MASK_EN
        .ch_mask(b_mask),
`endif
        .din(b_din), .dout(b_dout), .cur_ch(b_cur), .valid(b_valid), .wrap(b_wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model, one entry per instance: 0 = A, 1 = B.
    int         NCH[2]   = '{4, 3};
    int         WID[2]   = '{1, 8};
    int         DWL[2]   = '{4, 1};
    bit         m_scan[2];
    int         m_ch[2];
    int         m_cnt[2];
    logic [7:0] m_dout[2];
    bit         m_valid[2];
    bit         m_wrap[2];

    function automatic logic [7:0] chan(int d, logic [31:0] dn, int c);
        return 8'((dn >> (c * WID[d])) & ((32'd1 << WID[d]) - 1));
    endfunction

    function automatic void model_step(int d, bit r, bit e, bit md, int s,
                                       logic [31:0] dn, logic [15:0] mk);
        int n = NCH[d];
        bit any = 1'b0;
        for (int c = 0; c < n; c++) if (mk[c]) any = 1'b1;
        if (r) begin
            m_scan[d] = 0; m_ch[d] = 0; m_cnt[d] = 0;
            m_dout[d] = 0; m_valid[d] = 0; m_wrap[d] = 0;
        end else if (!e) begin
            m_wrap[d] = 0;
        end else if (!md) begin
            m_scan[d] = 0; m_cnt[d] = 0; m_wrap[d] = 0; m_ch[d] = s;
            m_valid[d] = (s < n) && mk[s];
            m_dout[d]  = m_valid[d] ? chan(d, dn, s) : 8'h00;
        end else if (!m_scan[d]) begin
            m_scan[d] = 1; m_cnt[d] = 0; m_wrap[d] = 0;
            if (m_ch[d] >= n) m_ch[d] = 0;
            m_valid[d] = mk[m_ch[d]];
            m_dout[d]  = m_valid[d] ? chan(d, dn, m_ch[d]) : 8'h00;
        end else if (m_cnt[d] == DWL[d] - 1) begin
            m_cnt[d] = 0;
            if (!any) begin
                m_valid[d] = 0; m_dout[d] = 0; m_wrap[d] = 0;
            end else begin
                for (int i = 1; i <= n; i++) begin
                    if (mk[(m_ch[d] + i) % n]) begin
                        m_wrap[d] = (m_ch[d] + i) >= n;
                        m_ch[d]   = (m_ch[d] + i) % n;
                        break;
                    end
                end
                m_valid[d] = 1;
                m_dout[d]  = chan(d, dn, m_ch[d]);
            end
        end else begin
            m_cnt[d]   = m_cnt[d] + 1;
            m_wrap[d]  = 0;
            m_valid[d] = mk[m_ch[d]];
            m_dout[d]  = m_valid[d] ? chan(d, dn, m_ch[d]) : 8'h00;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(0, rst, en, mode, sel, {28'b0, a_din}, {12'b0, a_mask});
        model_step(1, rst, en, mode, sel, {8'b0, b_din}, {13'b0, b_mask});
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 1; mode = 1; sel = 2'd2; a_din = 4'b1111; b_din = 24'hFFFFFF;
        for (int i = 0; i < 2; i++) tick();
        checks++;
        if ({a_dout, a_cur, a_valid, a_wrap} !== 5'b0 || {b_dout, b_cur, b_valid, b_wrap} !== 12'b0) begin
            errors++;
            $display("FAIL reset_const: got A=%h B=%h expected A=00 B=000", {a_dout, a_cur, a_valid, a_wrap}, {b_dout, b_cur, b_valid, b_wrap});
        end
        rst = 0; en = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({a_dout, a_cur, a_valid, a_wrap} !== {m_dout[0][0], 2'(m_ch[0]), m_valid[0], m_wrap[0]}) begin
                errors++;
                $display("FAIL hold_a: got %h expected %h", {a_dout, a_cur, a_valid, a_wrap}, {m_dout[0][0], 2'(m_ch[0]), m_valid[0], m_wrap[0]});
            end
            checks++;
            if ({b_dout, b_cur, b_valid, b_wrap} !== {m_dout[1], 2'(m_ch[1]), m_valid[1], m_wrap[1]}) begin
                errors++;
                $display("FAIL hold_b: got %h expected %h", {b_dout, b_cur, b_valid, b_wrap}, {m_dout[1], 2'(m_ch[1]), m_valid[1], m_wrap[1]});
            end
        end
    endtask

    task automatic test_manual_sweep();
        logic [3:0]  pat   = 4'b1010;
        logic [23:0] bytes = 24'hCCBBAA;
        logic [7:0]  exp_b;
        en = 1; mode = 0; a_din = pat; b_din = bytes;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            tick();
            checks++;
            if ({a_dout, a_cur, a_valid, a_wrap} !== {pat[s], 2'(s), 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL manual_a sel=%0d: got %h expected %h", s, {a_dout, a_cur, a_valid, a_wrap}, {pat[s], 2'(s), 1'b1, 1'b0});
            end
            exp_b = (s == 3) ? 8'h00 : 8'(bytes >> (8 * s));
            checks++;
            if ({b_dout, b_cur, b_valid, b_wrap} !== {exp_b, 2'(s), s != 3, 1'b0}) begin
                errors++;
                $display("FAIL manual_b sel=%0d: got %h expected %h", s, {b_dout, b_cur, b_valid, b_wrap}, {exp_b, 2'(s), s != 3, 1'b0});
            end
        end
    endtask

    task automatic test_auto_scan();
        logic [3:0] pat = 4'b0110;
        int ch;
        sel = 0; mode = 0;
        tick();
        a_din = pat; mode = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            ch = (k / 4) % 4;
            checks++;
            if ({a_dout, a_cur, a_valid, a_wrap} !== {pat[ch], 2'(ch), 1'b1, k == 16}) begin
                errors++;
                $display("FAIL scan_a k=%0d: got %h expected %h", k, {a_dout, a_cur, a_valid, a_wrap}, {pat[ch], 2'(ch), 1'b1, k == 16});
            end
            checks++;
            if ({b_dout, b_cur, b_valid, b_wrap} !== {m_dout[1], 2'(m_ch[1]), m_valid[1], m_wrap[1]}) begin
                errors++;
                $display("FAIL scan_b k=%0d: got %h expected %h", k, {b_dout, b_cur, b_valid, b_wrap}, {m_dout[1], 2'(m_ch[1]), m_valid[1], m_wrap[1]});
            end
        end
    endtask

    task automatic test_mid_events();
        int budget = 0;
        while (!(m_ch[0] == 2 && m_cnt[0] == 2) && budget < 64) begin
            tick();
            budget++;
        end
        checks++;
        if (budget >= 64) begin
            errors++;
            $display("FAIL mid_reach: got no dwell-2/ch-2 point in %0d cycles, required one", budget);
        end
        en = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({a_dout, a_cur, a_valid, a_wrap} !== {m_dout[0][0], 2'd2, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL mid_hold_a: got %h expected %h", {a_dout, a_cur, a_valid, a_wrap}, {m_dout[0][0], 2'd2, 1'b1, 1'b0});
            end
        end
        en = 1; mode = 0; sel = 0;
        tick();
        checks++;
        if (a_cur !== 2'd0 || a_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_to_manual: got cur_ch=%0d valid=%0b expected cur_ch=0 valid=1", a_cur, a_valid);
        end
        mode = 1; a_din = 4'b1111; b_din = 24'hFFFFFF;
        for (int i = 0; i < 3; i++) tick();
        rst = 1;
        tick();
        checks++;
        if ({a_dout, a_cur, a_valid, a_wrap} !== 5'b0 || {b_dout, b_cur, b_valid, b_wrap} !== 12'b0) begin
            errors++;
            $display("FAIL mid_reset: got A=%h B=%h expected A=00 B=000", {a_dout, a_cur, a_valid, a_wrap}, {b_dout, b_cur, b_valid, b_wrap});
        end
        rst = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({a_dout, a_cur, a_valid, a_wrap} !== {m_dout[0][0], 2'(m_ch[0]), m_valid[0], m_wrap[0]}) begin
                errors++;
                $display("FAIL post_reset_a: got %h expected %h", {a_dout, a_cur, a_valid, a_wrap}, {m_dout[0][0], 2'(m_ch[0]), m_valid[0], m_wrap[0]});
            end
        end
    endtask

`ifdef MUX_SCAN_MASK_EN
    task automatic test_mask();
        int b_wraps = 0;
        a_mask = 4'b1010; b_mask = 3'b101; mode = 0; sel = 0; en = 1;
        tick();
        checks++;
        if (a_valid !== 1'b0 || a_dout !== 1'b0) begin
            errors++;
            $display("FAIL mask_manual_a: got valid=%0b dout=%0b expected 0 0", a_valid, a_dout);
        end
        mode = 1;
        for (int k = 0; k < 21; k++) begin
            tick();
            if (b_wrap === 1'b1) b_wraps++;
            checks++;
            if ({a_dout, a_cur, a_valid, a_wrap} !== {m_dout[0][0], 2'(m_ch[0]), m_valid[0], m_wrap[0]}) begin
                errors++;
                $display("FAIL mask_a k=%0d: got %h expected %h", k, {a_dout, a_cur, a_valid, a_wrap}, {m_dout[0][0], 2'(m_ch[0]), m_valid[0], m_wrap[0]});
            end
            checks++;
            if ({b_dout, b_cur, b_valid, b_wrap} !== {m_dout[1], 2'(m_ch[1]), m_valid[1], m_wrap[1]}) begin
                errors++;
                $display("FAIL mask_b k=%0d: got %h expected %h", k, {b_dout, b_cur, b_valid, b_wrap}, {m_dout[1], 2'(m_ch[1]), m_valid[1], m_wrap[1]});
            end
        end
        checks++;
        if (b_wraps != 10) begin
            errors++;
            $display("FAIL mask_b_wraps: got %0d wrap pulses expected 10", b_wraps);
        end
        a_mask = 4'b0000; b_mask = 3'b000;
        for (int k = 0; k < 6; k++) tick();
        checks++;
        if ({a_dout, a_valid, a_wrap} !== 3'b0 || {b_dout, b_valid, b_wrap} !== 10'b0) begin
            errors++;
            $display("FAIL mask_zero: got A=%h B=%h expected zeros", {a_dout, a_valid, a_wrap}, {b_dout, b_valid, b_wrap});
        end
        a_mask = '1; b_mask = '1;
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rst   = ($urandom_range(0, 49) == 0);
            en    = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            sel   = 2'($urandom_range(0, 3));
            a_din = 4'($urandom);
            b_din = 24'($urandom);
`ifdef MUX_SCAN_MASK_EN
            if ($urandom_range(0, 19) == 0) begin
                a_mask = 4'($urandom);
                b_mask = 3'($urandom);
            end
`endif
            tick();
            checks++;
            if ({a_dout, a_cur, a_valid, a_wrap} !== {m_dout[0][0], 2'(m_ch[0]), m_valid[0], m_wrap[0]}) begin
                errors++;
                $display("FAIL rand_a k=%0d: got %h expected %h", k, {a_dout, a_cur, a_valid, a_wrap}, {m_dout[0][0], 2'(m_ch[0]), m_valid[0], m_wrap[0]});
            end
            checks++;
            if ({b_dout, b_cur, b_valid, b_wrap} !== {m_dout[1], 2'(m_ch[1]), m_valid[1], m_wrap[1]}) begin
                errors++;
                $display("FAIL rand_b k=%0d: got %h expected %h", k, {b_dout, b_cur, b_valid, b_wrap}, {m_dout[1], 2'(m_ch[1]), m_valid[1], m_wrap[1]});
            end
        end
        rst = 0; en = 1;
    endtask

    initial begin
        rst = 1; en = 0; mode = 0; sel = 0; a_din = 0; b_din = 0;
        a_mask = '1; b_mask = '1;
        test_reset();
        test_manual_sweep();
        test_auto_scan();
        test_mid_events();
`ifdef MUX_SCAN_MASK_EN
        test_mask();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_scan_reg.md
Name: mux_scan_reg

Overview:
- Parametrised, registered N-channel, W-bit multiplexer; successor to the combinational 4:1 single-bit mux.
- Two modes:
  - Manual: select driven externally.
  - Auto-scan: an internal dwell counter steps the select round-robin through all channels.
- Sits between lab input banks (switches/generators) and the display/LED datapath. Gives a clocked, glitch-free output plus the active channel index.

Parameters:
- N_CH, 4, number of input channels (2..16).
- DW, 1, data width per channel in bits.
- DWELL, 4, clock cycles spent on each channel in auto-scan (>=1).
- SELW, $clog2(N_CH), select/index width (derived; localparam).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  clock enable; when 0, all state and outputs hold.
- mode  input  1  0 = manual, 1 = auto-scan.
- sel  input  SELW  manual channel select.
- din  input  N_CH*DW  packed channels; channel k = din[k*DW +: DW].
- dout  output  DW  registered selected data.
- cur_ch  output  SELW  channel driving dout this cycle.
- valid  output  1  dout reflects a legal channel.
- wrap  output  1  one-cycle pulse when the scan passes from channel N_CH-1 to 0.

Behaviour:
- Reset (rst=1 at a rising edge):
  - dout=0, cur_ch=0, valid=0, wrap=0.
  - Dwell counter=0, state=MANUAL.
  - rst overrides en.
- States: MANUAL, SCAN. The transition is evaluated every enabled cycle from mode:
  - MANUAL->SCAN when mode=1. Scan starts at the current cur_ch with the dwell counter cleared.
  - SCAN->MANUAL when mode=0. cur_ch takes sel on that same edge.
- MANUAL:
  - cur_ch<=sel.
  - If sel<N_CH: dout<=din[sel], valid<=1.
  - Otherwise (N_CH not a power of 2): dout<=0, valid<=0.
  - Latency is 1 cycle from sel/din to dout.
- SCAN:
  - The dwell counter counts 0..DWELL-1.
  - When it reaches DWELL-1, it clears, and cur_ch advances: cur_ch+1, or 0 after N_CH-1.
  - wrap<=1 only on the N_CH-1 -> 0 step; otherwise wrap<=0.
  - dout<=din[cur_ch] of the next value, so dout and cur_ch always change on the same edge.
  - valid<=1.
  - din is resampled every cycle while dwelling, so dout tracks live data.
- DWELL=1: the channel advances every enabled cycle; a full rotation takes N_CH cycles.
- en=0: counter, cur_ch, dout and valid hold. wrap is forced to 0 (no stretched pulse).
- Mode toggling mid-dwell:
  - Counter progress is discarded.
  - Returning to SCAN restarts the dwell at 0 on the current channel.
- Reset mid-scan: next cycle is MANUAL state with all outputs 0, regardless of mode. The mode change is evaluated from the following edge.
- No combinational path from any input to any output.

Optional Feature:
- Macro MUX_SCAN_MASK_EN.
- When defined:
  - Adds input port ch_mask [N_CH-1:0]; 1 = channel enabled.
  - SCAN skips masked channels: it steps to the next enabled index, wrapping modulo N_CH. wrap pulses whenever the advance passes index N_CH-1.
  - In MANUAL, selecting a masked channel gives dout=0, valid=0.
  - If ch_mask is all zero: valid=0, dout=0, cur_ch holds, no wrap.
- When undefined: no ch_mask port; all channels are always enabled, behaviour as above.

Test Plan:
- Reset/hold:
  - Apply rst=1 for 2 cycles with din=4'b1111, mode=1 -> dout=0, cur_ch=0, valid=0, wrap=0.
  - Then rst=0, en=0 for 5 cycles -> outputs unchanged.
- Manual sweep (N_CH=4, DW=1): en=1, mode=0, din=4'b1010, sel=0,1,2,3 on successive cycles -> dout=0,1,0,1 each one cycle later; cur_ch follows sel; valid=1.
- Auto-scan (N_CH=4, DWELL=4): mode=1 from cur_ch=0, din constant 4'b0110:
  - cur_ch=0 for 4 cycles, then 1, 2, 3, 0.
  - dout=0,1,1,0.
  - wrap high exactly one cycle, at the 3->0 edge (cycle 16 after entry).
- Illegal select (N_CH=3, DW=8): din={8'hCC,8'hBB,8'hAA}, sel=3 -> dout=8'h00, valid=0; sel=1 -> dout=8'hBB, valid=1.
- Mid-operation events:
  - In SCAN at dwell count 2 on channel 2: drop en for 3 cycles -> no change. Set mode=0 with sel=0 -> next edge cur_ch=0.
  - Assert rst during SCAN -> next edge all outputs 0.
- MUX_SCAN_MASK_EN:
  - ch_mask=4'b1010, DWELL=1 -> cur_ch sequence 1,3,1,3; wrap pulses on each 3->1 step.
  - ch_mask=0 -> valid=0, dout=0.
